// File: rtl/ysyx_25020037_scoreboard_pkg.sv
// Shared types and constants for the issue scoreboard.
// One entry per in-flight register-writing instruction.
package ysyx_25020037_scoreboard_pkg;

    localparam int NREG  = 16;
    localparam int REG_W = 4;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             is_load;
    } sb_entry_t;

endpackage

// File: rtl/ysyx_25020037_sb_fifo.sv
// Circular buffer of in-flight writers: head/tail/count plus the oldest-load search.
// All events in a cycle act on pre-cycle state; push never targets a valid slot because full blocks it.
module ysyx_25020037_sb_fifo
    import ysyx_25020037_scoreboard_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [REG_W-1:0]           push_rd,
    input  logic                       push_is_load,
    input  logic                       pop,
    input  logic                       ld_done,
    output sb_entry_t [DEPTH-1:0]      entries,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    sb_entry_t [DEPTH-1:0] ent_q, ent_d;
    logic [PW-1:0]         head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]         cnt_q, cnt_d;

    logic          do_push, do_pop;
    logic          ld_hit;
    logic [PW-1:0] ld_idx, scan_idx;

    assign do_pop  = pop && (cnt_q != '0);
    assign do_push = push && (cnt_q != CW'(DEPTH));

    // Scan from the youngest offset down so the entry nearest head wins.
    always_comb begin
        ld_hit   = 1'b0;
        ld_idx   = '0;
        scan_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            scan_idx = head_q + PW'(i);
            if (ent_q[scan_idx].valid && ent_q[scan_idx].is_load) begin
                ld_hit = 1'b1;
                ld_idx = scan_idx;
            end
        end
    end

    always_comb begin
        ent_d  = ent_q;
        head_d = head_q;
        tail_d = tail_q;
        if (ld_done && ld_hit) begin
            ent_d[ld_idx].is_load = 1'b0;
        end
        if (do_pop) begin
            ent_d[head_q] = '0;
            head_d        = head_q + PW'(1);
        end
        if (do_push) begin
            ent_d[tail_q] = '{valid: 1'b1, rd: push_rd, is_load: push_is_load};
            tail_d        = tail_q + PW'(1);
        end
        cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ent_q  <= '0;
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            ent_q  <= ent_d;
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    assign entries = ent_q;
    assign count   = cnt_q;
    assign full    = (cnt_q == CW'(DEPTH));
    assign empty   = (cnt_q == '0);

endmodule

// File: rtl/ysyx_25020037_scoreboard.sv
// In-order issue scoreboard between IDU and EXU: holds issue on load-use (or any RAW when BYPASS=0).
// Hazard looks only at registered entries, so releases always appear one cycle after the event.
module ysyx_25020037_scoreboard
    import ysyx_25020037_scoreboard_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int BYPASS = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   iss_valid,
    input  logic [REG_W-1:0]       iss_rs1,
    input  logic [REG_W-1:0]       iss_rs2,
    input  logic                   iss_use_rs1,
    input  logic                   iss_use_rs2,
    input  logic [REG_W-1:0]       iss_rd,
    input  logic                   iss_gpr_we,
    input  logic                   iss_is_load,
    input  logic                   exu_ready,
    output logic                   iss_ready,
    input  logic                   ld_done,
    input  logic                   wb_valid,
    output logic                   stall_load,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] inflight_cnt
);

    sb_entry_t [DEPTH-1:0] ent;
    logic [DEPTH-1:0]      match, ld_match;
    logic                  hazard, fire, push;

    for (genvar g = 0; g < DEPTH; g++) begin : g_match
        logic hit1, hit2;
        assign hit1        = iss_use_rs1 && (iss_rs1 != '0) && ent[g].valid && (ent[g].rd == iss_rs1);
        assign hit2        = iss_use_rs2 && (iss_rs2 != '0) && ent[g].valid && (ent[g].rd == iss_rs2);
        assign match[g]    = hit1 || hit2;
        assign ld_match[g] = match[g] && ent[g].is_load;
    end

    assign hazard     = (BYPASS != 0) ? (|ld_match) : (|match);
    assign stall_load = iss_valid && (|ld_match);
    // Full blocks every issue, even non-writers, so push never needs a space check here.
    assign iss_ready  = exu_ready && !hazard && !full;
    assign fire       = iss_valid && iss_ready;
    assign push       = fire && iss_gpr_we && (iss_rd != '0);

    ysyx_25020037_sb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push         (push),
        .push_rd      (iss_rd),
        .push_is_load (iss_is_load),
        .pop          (wb_valid),
        .ld_done      (ld_done),
        .entries      (ent),
        .count        (inflight_cnt),
        .full         (full),
        .empty        (empty)
    );

endmodule
